// File: rtl/remap_post_wr_pkg.sv
// Shared definitions for the remap write-back path.
//   - Default slice count, slice row width and RTM depth.
//   - RTM row-address width derivation.
//   - FSM state encoding (IDLE / RUN / DRAIN).
package remap_post_wr_pkg;

  localparam int S_DEF         = 8;
  localparam int R_DEF         = 16;
  localparam int RTM_DEPTH_DEF = 4096;

  // Row-address width; a one-row RTM still needs a 1-bit address.
  function automatic int aw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/remap_post_wr_shift_reg.sv
// Fixed-depth register delay line with synchronous active-high clear.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears every stage
//   d_i  - input word
//   q_o  - input word delayed by DEPTH cycles
module remap_post_wr_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stg_q [DEPTH];

  // Every stage is cleared so in-flight beats vanish on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign q_o = stg_q[DEPTH-1];

endmodule

// File: rtl/remap_post_wr.sv
// Write-back end of the remap path: takes requantized PPU rows and writes them
// into RTM at consecutive rows starting from Y_addr, checking the row count
// against len_minus_1 and signalling completion.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   start_pulse               - instruction start; latches Y_addr, len_minus_1
//   Y_addr, len_minus_1       - first RTM row, number of rows minus one
//   ppus_Ys / _vld / _last    - PPU row data, valid, final-row marker
//   rtm_wr_vld / _last        - write beat valid, final write beat
//   rtm_wr_en, rtm_wr_addr    - per-slice write enable and row address
//   rtm_din                   - write data, slice i at [i*R*8 +: R*8]
//   busy                      - instruction in progress
//   done_pulse                - one cycle after the final write has left
//   err                       - sticky protocol error, cleared by start or rst
module remap_post_wr
  import remap_post_wr_pkg::*;
#(
  parameter  int S          = S_DEF,
  parameter  int R          = R_DEF,
  parameter  int RTM_DEPTH  = RTM_DEPTH_DEF,
  parameter  int EXTRA_PIPE = 0,
  localparam int AW         = aw_of(RTM_DEPTH),
  localparam int DW         = S * R * 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_pulse,
  input  logic [AW-1:0]   Y_addr,
  input  logic [AW-1:0]   len_minus_1,
  input  logic [DW-1:0]   ppus_Ys,
  input  logic            ppus_Ys_vld,
  input  logic            ppus_Ys_last,
  output logic            rtm_wr_vld,
  output logic            rtm_wr_last,
  output logic [S-1:0]    rtm_wr_en,
  output logic [S*AW-1:0] rtm_wr_addr,
  output logic [DW-1:0]   rtm_din,
  output logic            busy,
  output logic            done_pulse,
  output logic            err
);

  localparam int          PW      = 2 + S + S * AW + DW;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(RTM_DEPTH);

  // Row address modulo RTM_DEPTH; also correct for non power-of-two depths.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a,
                                             input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DEPTH_W) s = s - DEPTH_W;
    return s[AW-1:0];
  endfunction

  state_e        state_q;
  logic [AW-1:0] base_q, lim_q, cnt_q;
  logic          dcnt_q;
  logic          err_q, err_d;
  logic          done_q;

  logic          acc, at_lim, fin;
  logic [AW-1:0] wr_addr;

  assign acc     = (state_q == ST_RUN) && ppus_Ys_vld;
  assign at_lim  = (cnt_q == lim_q);
  // The instruction always ends at lim, even when last never arrives.
  assign fin     = acc && (ppus_Ys_last || at_lim);
  assign wr_addr = wrap_add(base_q, cnt_q);

  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && start_pulse) err_d = 1'b0;
    // Early last, or lim reached without last: both show as last != at_lim.
    if (acc && (ppus_Ys_last != at_lim))    err_d = 1'b1;
    if (ppus_Ys_vld && (state_q != ST_RUN)) err_d = 1'b1;
    if (start_pulse && (state_q != ST_IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      lim_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= err_d;
      unique case (state_q)
        ST_IDLE: begin
          if (start_pulse) begin
            state_q <= ST_RUN;
            base_q  <= Y_addr;
            lim_q   <= len_minus_1;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          if (acc) begin
            cnt_q <= cnt_q + AW'(1);
            if (fin) begin
              state_q <= ST_DRAIN;
              dcnt_q  <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // Hold until the final beat is on the RTM port, then pulse done.
          if (dcnt_q == 1'(EXTRA_PIPE)) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            dcnt_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p0: accepted beat registered towards RTM ----
  logic            vld_p0, last_p0;
  logic [S-1:0]    en_p0;
  logic [S*AW-1:0] addr_p0;
  logic [DW-1:0]   din_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      en_p0   <= '0;
      addr_p0 <= '0;
      din_p0  <= '0;
    end else begin
      vld_p0  <= acc;
      last_p0 <= acc && at_lim;
      en_p0   <= {S{acc}};
      addr_p0 <= acc ? {S{wr_addr}} : '0;
      din_p0  <= acc ? ppus_Ys : '0;
    end
  end

  // ---- stage p1: optional extra register on the whole beat ----
  logic [PW-1:0] beat_p0, beat_p1;

  assign beat_p0 = {vld_p0, last_p0, en_p0, addr_p0, din_p0};

  if (EXTRA_PIPE != 0) begin : g_extra
    remap_post_wr_shift_reg #(
      .WIDTH (PW),
      .DEPTH (1)
    ) u_pipe (
      .clk (clk),
      .rst (rst),
      .d_i (beat_p0),
      .q_o (beat_p1)
    );
  end else begin : g_direct
    assign beat_p1 = beat_p0;
  end

  assign {rtm_wr_vld, rtm_wr_last, rtm_wr_en, rtm_wr_addr, rtm_din} = beat_p1;

  assign busy       = (state_q != ST_IDLE);
  assign done_pulse = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_remap_post_wr.sv
module tb_remap_post_wr;
  localparam int S     = 8;
  localparam int R     = 16;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int DW    = S * R * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst, start_pulse, ppus_Ys_vld, ppus_Ys_last;
  logic [AW-1:0] Y_addr, len_minus_1;
  logic [DW-1:0] ppus_Ys;

  logic            wv[2], wl[2], busy[2], done[2], err[2];
  logic [S-1:0]    en[2];
  logic [S*AW-1:0] addr[2];
  logic [DW-1:0]   din[2];

  remap_post_wr #(.S(S), .R(R), .RTM_DEPTH(DEPTH), .EXTRA_PIPE(0)) u0 (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .Y_addr(Y_addr),
    .len_minus_1(len_minus_1), .ppus_Ys(ppus_Ys), .ppus_Ys_vld(ppus_Ys_vld),
    .ppus_Ys_last(ppus_Ys_last), .rtm_wr_vld(wv[0]), .rtm_wr_last(wl[0]),
    .rtm_wr_en(en[0]), .rtm_wr_addr(addr[0]), .rtm_din(din[0]),
    .busy(busy[0]), .done_pulse(done[0]), .err(err[0]));

  remap_post_wr #(.S(S), .R(R), .RTM_DEPTH(DEPTH), .EXTRA_PIPE(1)) u1 (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .Y_addr(Y_addr),
    .len_minus_1(len_minus_1), .ppus_Ys(ppus_Ys), .ppus_Ys_vld(ppus_Ys_vld),
    .ppus_Ys_last(ppus_Ys_last), .rtm_wr_vld(wv[1]), .rtm_wr_last(wl[1]),
    .rtm_wr_en(en[1]), .rtm_wr_addr(addr[1]), .rtm_din(din[1]),
    .busy(busy[1]), .done_pulse(done[1]), .err(err[1]));

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    logic          ok;
  } wr_t;

  wr_t got0[$], got1[$];
  int  dn0[$], dn1[$];

  // Reference model results for one instruction (cycles are input cycles).
  wr_t  exp_q[$];
  int   exp_end;
  logic exp_err;
  int   vpat[$], lpat[$];

  int checks = 0;
  int errors = 0;

  function automatic wr_t capture(input int d);
    wr_t w;
    w.cyc  = cyc;
    w.addr = addr[d][AW-1:0];
    w.data = din[d];
    w.last = wl[d];
    w.ok   = (en[d] == {S{1'b1}});
    for (int s = 1; s < S; s++) if (addr[d][s*AW +: AW] != w.addr) w.ok = 1'b0;
    return w;
  endfunction

  always @(negedge clk) begin
    if (wv[0])   got0.push_back(capture(0));
    if (wv[1])   got1.push_back(capture(1));
    if (done[0]) dn0.push_back(cyc);
    if (done[1]) dn1.push_back(cyc);
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_obs();
    got0.delete(); got1.delete(); dn0.delete(); dn1.delete();
  endtask

  task automatic set_pat(input int rows, input int last_row);
    vpat.delete(); lpat.delete();
    for (int i = 0; i < rows; i++) begin
      vpat.push_back(1);
      lpat.push_back(i == last_row ? 1 : 0);
    end
  endtask

  // Drives one instruction from vpat/lpat and predicts its writes: row k of
  // the instruction goes to (base + k) mod DEPTH, the instruction ends on
  // the first row that carries last or is row number lim.
  task automatic run_scenario(input logic [AW-1:0] base, input logic [AW-1:0] lim,
                              input int busy_at);
    int  cnt;
    bit  running;
    wr_t w;
    clear_obs();
    exp_q.delete();
    exp_end = -1; exp_err = 1'b0; cnt = 0; running = 1'b1;
    @(posedge clk); #1;
    start_pulse = 1'b1; Y_addr = base; len_minus_1 = lim;
    for (int i = 0; i < vpat.size(); i++) begin
      @(posedge clk); #1;
      start_pulse  = (i == busy_at);
      Y_addr       = AW'($urandom);
      len_minus_1  = AW'($urandom);
      ppus_Ys_vld  = vpat[i][0];
      ppus_Ys_last = lpat[i][0];
      ppus_Ys      = rnd_data();
      if (i == busy_at) exp_err = 1'b1;
      if (ppus_Ys_vld) begin
        if (running) begin
          w.cyc = cyc; w.addr = AW'((int'(base) + cnt) % DEPTH);
          w.data = ppus_Ys; w.last = (cnt == int'(lim)); w.ok = 1'b1;
          exp_q.push_back(w);
          if (ppus_Ys_last != (cnt == int'(lim))) exp_err = 1'b1;
          if (ppus_Ys_last || cnt == int'(lim)) begin running = 1'b0; exp_end = cyc; end
          cnt++;
        end else begin
          exp_err = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    start_pulse = 1'b0; ppus_Ys_vld = 1'b0; ppus_Ys_last = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wv[d] !== 1'b0 || wl[d] !== 1'b0 || en[d] !== '0 || addr[d] !== '0 || din[d] !== '0 ||
          busy[d] !== 1'b0 || done[d] !== 1'b0 || err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d got vld=%b last=%b en=%h addr=%h busy=%b done=%b err=%b want all 0",
                 d, wv[d], wl[d], en[d], addr[d], busy[d], done[d], err[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin set_pat(4, 3); run_scenario(12'h010, 12'd3, -1); end
      else        begin set_pat(1, 0); run_scenario(12'h7A5, 12'd0, -1); end
      for (int d = 0; d < 2; d++) begin
        wr_t g[$]; int dn[$];
        if (d == 0) begin g = got0; dn = dn0; end else begin g = got1; dn = dn1; end
        checks++;
        if (g.size() != exp_q.size()) begin
          errors++; $display("FAIL normal%0d_count dut%0d got %0d want %0d", c, d, g.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < g.size()) begin
          checks++;
          if (g[i].cyc != exp_q[i].cyc + 1 + d || g[i].addr !== exp_q[i].addr || g[i].data !== exp_q[i].data ||
              g[i].last !== exp_q[i].last || g[i].ok !== 1'b1) begin
            errors++;
            $display("FAIL normal%0d_wr%0d dut%0d got cyc=%0d addr=%h last=%b ok=%b d=%h want cyc=%0d addr=%h last=%b ok=1 d=%h",
                     c, i, d, g[i].cyc, g[i].addr, g[i].last, g[i].ok, g[i].data[31:0],
                     exp_q[i].cyc + 1 + d, exp_q[i].addr, exp_q[i].last, exp_q[i].data[31:0]);
          end
        end
        checks++;
        if (dn.size() != 1 || dn[0] != exp_end + 2 + d) begin
          errors++; $display("FAIL normal%0d_done dut%0d got n=%0d cyc=%0d want n=1 cyc=%0d",
                             c, d, dn.size(), dn.size() > 0 ? dn[0] : -1, exp_end + 2 + d);
        end
        checks++;
        if (err[d] !== exp_err || busy[d] !== 1'b0) begin
          errors++; $display("FAIL normal%0d_err dut%0d got err=%b busy=%b want err=%b busy=0",
                             c, d, err[d], busy[d], exp_err);
        end
      end
    end
  endtask

  task automatic test_wrap();
    set_pat(4, 3);
    run_scenario(AW'(DEPTH - 2), 12'd3, -1);
    for (int d = 0; d < 2; d++) begin
      wr_t g[$]; int dn[$];
      if (d == 0) begin g = got0; dn = dn0; end else begin g = got1; dn = dn1; end
      checks++;
      if (g.size() != exp_q.size()) begin
        errors++; $display("FAIL wrap_count dut%0d got %0d want %0d", d, g.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < g.size()) begin
        checks++;
        if (g[i].cyc != exp_q[i].cyc + 1 + d || g[i].addr !== exp_q[i].addr || g[i].data !== exp_q[i].data ||
            g[i].last !== exp_q[i].last || g[i].ok !== 1'b1) begin
          errors++;
          $display("FAIL wrap_wr%0d dut%0d got cyc=%0d addr=%h last=%b ok=%b want cyc=%0d addr=%h last=%b ok=1",
                   i, d, g[i].cyc, g[i].addr, g[i].last, g[i].ok,
                   exp_q[i].cyc + 1 + d, exp_q[i].addr, exp_q[i].last);
        end
      end
      checks++;
      if (dn.size() != 1 || dn[0] != exp_end + 2 + d || err[d] !== exp_err) begin
        errors++; $display("FAIL wrap_done dut%0d got n=%0d cyc=%0d err=%b want n=1 cyc=%0d err=%b",
                           d, dn.size(), dn.size() > 0 ? dn[0] : -1, err[d], exp_end + 2 + d, exp_err);
      end
    end
  endtask

  task automatic test_gapped();
    vpat = '{1, 0, 0, 1, 0, 1};
    lpat = '{0, 0, 0, 0, 0, 1};
    run_scenario(12'h300, 12'd2, -1);
    for (int d = 0; d < 2; d++) begin
      wr_t g[$]; int dn[$];
      if (d == 0) begin g = got0; dn = dn0; end else begin g = got1; dn = dn1; end
      checks++;
      if (g.size() != exp_q.size()) begin
        errors++; $display("FAIL gapped_count dut%0d got %0d want %0d", d, g.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < g.size()) begin
        checks++;
        if (g[i].cyc != exp_q[i].cyc + 1 + d || g[i].addr !== exp_q[i].addr || g[i].data !== exp_q[i].data ||
            g[i].last !== exp_q[i].last || g[i].ok !== 1'b1) begin
          errors++;
          $display("FAIL gapped_wr%0d dut%0d got cyc=%0d addr=%h last=%b d=%h want cyc=%0d addr=%h last=%b d=%h",
                   i, d, g[i].cyc, g[i].addr, g[i].last, g[i].data[31:0],
                   exp_q[i].cyc + 1 + d, exp_q[i].addr, exp_q[i].last, exp_q[i].data[31:0]);
        end
      end
      checks++;
      if (dn.size() != 1 || dn[0] != exp_end + 2 + d || err[d] !== exp_err) begin
        errors++; $display("FAIL gapped_done dut%0d got n=%0d cyc=%0d err=%b want n=1 cyc=%0d err=%b",
                           d, dn.size(), dn.size() > 0 ? dn[0] : -1, err[d], exp_end + 2 + d, exp_err);
      end
    end
  endtask

  task automatic test_mismatch();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin set_pat(2, 1);  run_scenario(12'h040, 12'd4, -1); end
      else        begin set_pat(2, -1); run_scenario(12'h080, 12'd1, -1); end
      for (int d = 0; d < 2; d++) begin
        wr_t g[$]; int dn[$];
        if (d == 0) begin g = got0; dn = dn0; end else begin g = got1; dn = dn1; end
        checks++;
        if (g.size() != exp_q.size()) begin
          errors++; $display("FAIL mismatch%0d_count dut%0d got %0d want %0d", c, d, g.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < g.size()) begin
          checks++;
          if (g[i].cyc != exp_q[i].cyc + 1 + d || g[i].addr !== exp_q[i].addr || g[i].data !== exp_q[i].data ||
              g[i].last !== exp_q[i].last || g[i].ok !== 1'b1) begin
            errors++;
            $display("FAIL mismatch%0d_wr%0d dut%0d got cyc=%0d addr=%h last=%b want cyc=%0d addr=%h last=%b",
                     c, i, d, g[i].cyc, g[i].addr, g[i].last, exp_q[i].cyc + 1 + d, exp_q[i].addr, exp_q[i].last);
          end
        end
        checks++;
        if (dn.size() != 1 || dn[0] != exp_end + 2 + d || err[d] !== exp_err) begin
          errors++; $display("FAIL mismatch%0d_done dut%0d got n=%0d cyc=%0d err=%b want n=1 cyc=%0d err=%b",
                             c, d, dn.size(), dn.size() > 0 ? dn[0] : -1, err[d], exp_end + 2 + d, exp_err);
        end
      end
    end
  endtask

  task automatic test_stray_overlap();
    clear_obs();
    @(posedge clk); #1;
    ppus_Ys_vld = 1'b1; ppus_Ys_last = 1'b1; ppus_Ys = rnd_data();
    @(posedge clk); #1;
    ppus_Ys_vld = 1'b0; ppus_Ys_last = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ((d == 0 ? got0.size() : got1.size()) != 0 || err[d] !== 1'b1 || busy[d] !== 1'b0) begin
        errors++; $display("FAIL stray_idle dut%0d got writes=%0d err=%b busy=%b want writes=0 err=1 busy=0",
                           d, d == 0 ? got0.size() : got1.size(), err[d], busy[d]);
      end
    end
    set_pat(4, 3);
    run_scenario(12'h5C0, 12'd3, 1);
    for (int d = 0; d < 2; d++) begin
      wr_t g[$]; int dn[$];
      if (d == 0) begin g = got0; dn = dn0; end else begin g = got1; dn = dn1; end
      checks++;
      if (g.size() != exp_q.size()) begin
        errors++; $display("FAIL overlap_count dut%0d got %0d want %0d", d, g.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < g.size()) begin
        checks++;
        if (g[i].cyc != exp_q[i].cyc + 1 + d || g[i].addr !== exp_q[i].addr || g[i].data !== exp_q[i].data ||
            g[i].last !== exp_q[i].last || g[i].ok !== 1'b1) begin
          errors++;
          $display("FAIL overlap_wr%0d dut%0d got cyc=%0d addr=%h last=%b want cyc=%0d addr=%h last=%b",
                   i, d, g[i].cyc, g[i].addr, g[i].last, exp_q[i].cyc + 1 + d, exp_q[i].addr, exp_q[i].last);
        end
      end
      checks++;
      if (dn.size() != 1 || dn[0] != exp_end + 2 + d || err[d] !== exp_err) begin
        errors++; $display("FAIL overlap_done dut%0d got n=%0d cyc=%0d err=%b want n=1 cyc=%0d err=%b",
                           d, dn.size(), dn.size() > 0 ? dn[0] : -1, err[d], exp_end + 2 + d, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    @(posedge clk); #1;
    start_pulse = 1'b1; Y_addr = 12'h100; len_minus_1 = 12'd4;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      start_pulse = 1'b0; ppus_Ys_vld = 1'b1; ppus_Ys_last = 1'b0; ppus_Ys = rnd_data();
    end
    @(posedge clk); #1;
    ppus_Ys_vld = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wv[d] !== 1'b0 || wl[d] !== 1'b0 || en[d] !== '0 || addr[d] !== '0 || din[d] !== '0 ||
          busy[d] !== 1'b0 || done[d] !== 1'b0 || err[d] !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_clear dut%0d got vld=%b en=%h addr=%h busy=%b err=%b want all 0",
                 d, wv[d], en[d], addr[d], busy[d], err[d]);
      end
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    // The slower pipeline still held the second beat when reset hit.
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ((d == 0 ? got0.size() : got1.size()) != 2 - d || (d == 0 ? dn0.size() : dn1.size()) != 0) begin
        errors++; $display("FAIL rstmid_flush dut%0d got writes=%0d dones=%0d want writes=%0d dones=0",
                           d, d == 0 ? got0.size() : got1.size(), d == 0 ? dn0.size() : dn1.size(), 2 - d);
      end
    end
    set_pat(3, 2);
    run_scenario(12'h200, 12'd2, -1);
    for (int d = 0; d < 2; d++) begin
      wr_t g[$]; int dn[$];
      if (d == 0) begin g = got0; dn = dn0; end else begin g = got1; dn = dn1; end
      checks++;
      if (g.size() != exp_q.size()) begin
        errors++; $display("FAIL rstmid_rerun_count dut%0d got %0d want %0d", d, g.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < g.size()) begin
        checks++;
        if (g[i].cyc != exp_q[i].cyc + 1 + d || g[i].addr !== exp_q[i].addr || g[i].data !== exp_q[i].data ||
            g[i].last !== exp_q[i].last || g[i].ok !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_rerun_wr%0d dut%0d got cyc=%0d addr=%h last=%b want cyc=%0d addr=%h last=%b",
                   i, d, g[i].cyc, g[i].addr, g[i].last, exp_q[i].cyc + 1 + d, exp_q[i].addr, exp_q[i].last);
        end
      end
      checks++;
      if (dn.size() != 1 || dn[0] != exp_end + 2 + d || err[d] !== 1'b0) begin
        errors++; $display("FAIL rstmid_rerun_done dut%0d got n=%0d cyc=%0d err=%b want n=1 cyc=%0d err=0",
                           d, dn.size(), dn.size() > 0 ? dn[0] : -1, err[d], exp_end + 2 + d);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int lim, mode, early;
      logic [AW-1:0] base;
      base = AW'($urandom);
      lim  = $urandom_range(0, 5);
      mode = $urandom_range(0, 3);
      early = (lim > 0) ? $urandom_range(0, lim - 1) : 0;
      vpat.delete(); lpat.delete();
      for (int r = 0; r <= lim; r++) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin vpat.push_back(0); lpat.push_back(0); end
        vpat.push_back(1);
        if (mode == 3 && lim > 0 && r == early) begin lpat.push_back(1); break; end
        lpat.push_back((mode < 2 && r == lim) ? 1 : 0);
      end
      run_scenario(base, AW'(lim), -1);
      for (int d = 0; d < 2; d++) begin
        wr_t g[$]; int dn[$];
        if (d == 0) begin g = got0; dn = dn0; end else begin g = got1; dn = dn1; end
        checks++;
        if (g.size() != exp_q.size()) begin
          errors++; $display("FAIL random%0d_count dut%0d got %0d want %0d", k, d, g.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < g.size()) begin
          checks++;
          if (g[i].cyc != exp_q[i].cyc + 1 + d || g[i].addr !== exp_q[i].addr || g[i].data !== exp_q[i].data ||
              g[i].last !== exp_q[i].last || g[i].ok !== 1'b1) begin
            errors++;
            $display("FAIL random%0d_wr%0d dut%0d got cyc=%0d addr=%h last=%b want cyc=%0d addr=%h last=%b",
                     k, i, d, g[i].cyc, g[i].addr, g[i].last, exp_q[i].cyc + 1 + d, exp_q[i].addr, exp_q[i].last);
          end
        end
        checks++;
        if (dn.size() != 1 || dn[0] != exp_end + 2 + d || err[d] !== exp_err) begin
          errors++; $display("FAIL random%0d_done dut%0d got n=%0d cyc=%0d err=%b want n=1 cyc=%0d err=%b",
                             k, d, dn.size(), dn.size() > 0 ? dn[0] : -1, err[d], exp_end + 2 + d, exp_err);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start_pulse = 1'b0; Y_addr = '0; len_minus_1 = '0;
    ppus_Ys = '0; ppus_Ys_vld = 1'b0; ppus_Ys_last = 1'b0;
    test_reset();
    test_normal();
    test_wrap();
    test_gapped();
    test_mismatch();
    test_stray_overlap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
